// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble, shift right then subtract 3).
// One shift step per clock, start/done handshake, err qualifies done for invalid digits.
module bcd_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [BCD_W-1:0]   bcd_reg, bcd_next;
  logic [BIN_W-1:0]   bin_reg, bin_next, bin_out_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               err_next;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  // Post-shift correction: any digit of 8..12 had a 10 shifted in from above, so take 3 back off.
  function automatic logic [BCD_W-1:0] correct_digits(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd8) begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Next-state and datapath update for the IDLE/CONV/DONE sequence.
  always_comb begin
    state_next   = state;
    bcd_next     = bcd_reg;
    bin_next     = bin_reg;
    cnt_next     = cnt;
    bin_out_next = bin_out;
    err_next     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (has_bad_digit(bcd_in)) begin
            state_next = DONE;
            err_next   = 1'b1;
          end else begin
            state_next = CONV;
            bcd_next   = bcd_in;
            bin_next   = '0;
            cnt_next   = '0;
          end
        end else begin
          state_next = IDLE;
        end
      end
      CONV: begin
        bin_next = {bcd_reg[0], bin_reg[BIN_W-1:1]};
        bcd_next = correct_digits({1'b0, bcd_reg[BCD_W-1:1]});
        cnt_next = cnt + CNT_W'(1);
        if (cnt == LAST_ITER) begin
          bin_out_next = bin_next;
          state_next   = DONE;
        end else begin
          state_next = CONV;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      bin_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_next;
      bcd_reg <= bcd_next;
      bin_reg <= bin_next;
      cnt     <= cnt_next;
      bin_out <= bin_out_next;
      busy    <= (state_next == CONV);
      done    <= (state_next == DONE);
      err     <= err_next;
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed testbench for bcd_to_bin_seq: latency, results, invalid digits, restart
// suppression, asynchronous reset abort and back-to-back throughput.
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd_in;
  logic [9:0]  bin_out;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge, then count cycles (sampled on negedges) until done; lat=-1 on timeout.
  task automatic run_conv(input logic [11:0] v, output int lat, output int busy_cnt);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = v;
    @(posedge clk);
    #1 start = 1'b0;
    bcd_in = 12'hFFF;
    lat = -1;
    busy_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = 12'h000;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bin_out, busy, done, err} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got bin_out=%0d busy=%b done=%b err=%b, want all 0", bin_out, busy, done, err);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc;
    run_conv(12'h999, lat, bc);
    n_cmp++;
    if (lat !== 11) begin n_err++; $display("FAIL basic_latency: got %0d, want 11", lat); end
    n_cmp++;
    if (bc !== 10) begin n_err++; $display("FAIL basic_busy_cycles: got %0d, want 10", bc); end
    n_cmp++;
    if (bin_out !== 10'h3E7) begin n_err++; $display("FAIL basic_value: got %0d, want 999", bin_out); end
    n_cmp++;
    if (err !== 1'b0) begin n_err++; $display("FAIL basic_err: got %b, want 0", err); end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_one_cycle: got %b, want 0", done); end
  endtask

  task automatic test_values();
    logic [11:0] vin [3] = '{12'h000, 12'h255, 12'h100};
    logic [9:0]  vexp[3] = '{10'd0, 10'd255, 10'd100};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_conv(vin[i], lat, bc);
      n_cmp++;
      if (lat !== 11 || bin_out !== vexp[i] || err !== 1'b0) begin
        n_err++;
        $display("FAIL value_%03h: got lat=%0d bin_out=%0d err=%b, want lat=11 bin_out=%0d err=0",
                 vin[i], lat, bin_out, err, vexp[i]);
      end
    end
  endtask

  task automatic test_invalid();
    int lat, bc;
    run_conv(12'h1A3, lat, bc);
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL invalid_latency: got %0d, want 1", lat); end
    n_cmp++;
    if (err !== 1'b1) begin n_err++; $display("FAIL invalid_err: got %b, want 1", err); end
    n_cmp++;
    if (bin_out !== 10'd100) begin n_err++; $display("FAIL invalid_hold: got %0d, want 100", bin_out); end
    n_cmp++;
    if (bc !== 0) begin n_err++; $display("FAIL invalid_busy: got %0d busy cycles, want 0", bc); end
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0) begin n_err++; $display("FAIL invalid_err_clear: got %b, want 0", err); end
  endtask

  task automatic test_ignore_restart();
    int lat = -1;
    int extra = 0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h042;
    @(posedge clk);
    #1 start = 1'b0;
    bcd_in = 12'h000;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 3) begin
        start  = 1'b1;
        bcd_in = 12'h777;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (lat !== 11 || bin_out !== 10'd42) begin
      n_err++;
      $display("FAIL restart_ignored: got lat=%0d bin_out=%0d, want lat=11 bin_out=42", lat, bin_out);
    end
    repeat (15) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin n_err++; $display("FAIL restart_no_second: got %0d active cycles, want 0", extra); end
  endtask

  task automatic test_async_reset();
    int lat, bc;
    int seen_done = 0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h999;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_before: got %b, want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || bin_out !== 10'd0) begin
      n_err++;
      $display("FAIL abort_immediate: got busy=%b done=%b bin_out=%0d, want 0 0 0", busy, done, bin_out);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    n_cmp++;
    if (seen_done !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d done pulses, want 0", seen_done); end
    run_conv(12'h500, lat, bc);
    n_cmp++;
    if (lat !== 11 || bin_out !== 10'd500 || err !== 1'b0) begin
      n_err++;
      $display("FAIL abort_recover: got lat=%0d bin_out=%0d err=%b, want 11 500 0", lat, bin_out, err);
    end
  endtask

  task automatic test_back_to_back();
    int t[$];
    int bad = 0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h321;
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      if (done) begin
        t.push_back(c);
        if (bin_out !== 10'd321 || err !== 1'b0) bad++;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (t.size() !== 3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d done pulses, want 3", t.size());
    end else begin
      n_cmp++;
      if (t[0] !== 11 || t[1] - t[0] !== 12 || t[2] - t[1] !== 12) begin
        n_err++;
        $display("FAIL b2b_spacing: got done at %0d,%0d,%0d, want 11,23,35", t[0], t[1], t[2]);
      end
    end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL b2b_values: got %0d bad results, want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_invalid();
    test_ignore_restart();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary converter using reverse double dabble: shift right, then subtract 3 from any BCD digit that is 8 or more.
- It is the inverse of the add-3 binary-to-BCD correction path in the ASCII adder.
- It takes packed BCD digits from the ASCII input stage and produces the binary operand the adder consumes.
- Handshake is start/done; one shift step per clock.

Parameters:
- DIGITS, 3, number of packed BCD digits on bcd_in.
- BIN_W, 10, binary result width. Must satisfy 2^BIN_W >= 10^DIGITS. It is also the iteration count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request a conversion. Sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD. Digit 0 is bits [3:0].
- bin_out  output  BIN_W  binary result. Held until the next successful conversion.
- busy  output  1  high while in state CONV.
- done  output  1  one-cycle completion pulse.
- err  output  1  qualifies done: an invalid digit was detected. Valid only while done=1; 0 otherwise.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE; bin_out=0; busy=0; done=0; err=0.
  - Internal BCD shift register=0; binary shift register=0; iteration counter=0.
  - Reset asserted mid-conversion aborts it immediately; bin_out returns to 0.
- States: IDLE, CONV, DONE. Encoding is free.
- IDLE:
  - If start=1 at the edge and every digit of bcd_in is <= 9: load bcd_in into the BCD register, clear the binary register and counter, go to CONV.
  - If start=1 and any digit is > 9: go to DONE with err flagged. bin_out is not changed.
  - start=0: stay in IDLE.
- CONV, one iteration per edge:
  - Shift the concatenation {bcd_reg, bin_reg} right by 1. bcd_reg LSB enters bin_reg MSB; 0 enters bcd_reg MSB.
  - Then, on the shifted value and in the same cycle, subtract 3 from each 4-bit digit that is >= 8. All digits are corrected in parallel.
  - Increment the counter. On the edge completing iteration BIN_W: bin_out <= final bin_reg, go to DONE.
- DONE:
  - done=1 and err=valid/invalid flag for exactly one cycle, then IDLE unconditionally.
- Latency:
  - Start accepted at edge N.
  - Valid input: busy=1 for cycles after edges N .. N+BIN_W-1. done=1 (err=0) in the cycle after edge N+BIN_W, with bin_out already updated.
  - Invalid input: done=1 and err=1 in the cycle after edge N.
- Restarts:
  - start is ignored in CONV and DONE; no queuing.
  - Earliest restart is the first IDLE cycle, so back-to-back throughput is one conversion per BIN_W+2 cycles.
- Input stability: bcd_in is sampled only at the accepting edge. Changes afterwards have no effect.
- Arithmetic:
  - Digit correction is unsigned 4-bit. A digit >= 8 after a shift is always in 8..12, so the result never underflows.
  - After BIN_W iterations the BCD register is all-zero for valid input. No overflow check is required given the parameter constraint.

Test Plan:
- Reset, then start with bcd_in=12'h999 -> done pulses 11 cycles after the start edge; bin_out=10'd999 (10'h3E7); err=0; busy high 10 cycles.
- bcd_in=12'h000, then 12'h255, then 12'h100, each after done -> bin_out 0, 255, 100 respectively; err=0 each time.
- bcd_in=12'h1A3 -> done pulses in the cycle after the start edge with err=1; bin_out keeps the previous value (100); busy never asserts.
- start=12'h042 accepted; start pulsed again at cycle 3 with bcd_in=12'h777 -> second start ignored; bin_out=42 at done; no second done unless start is reasserted in IDLE.
- start=12'h999, rst_n driven low at cycle 5 (asynchronously, mid-cycle) -> busy, done and bin_out go to 0 immediately, with no done pulse. After release, start with 12'h500 -> bin_out=500.
- start held high continuously with bcd_in=12'h321 -> a conversion every 12 cycles; each done shows bin_out=321 and err=0.
